// File: rtl/multiciclo_core.sv
// Multicycle RV32I/RV64I integer-ALU core: FETCH/DECODE/EXECUTE/WRITEBACK with an
// internal register file, valid/ready instruction fetch, and ECALL/EBREAK/illegal halt.
module multiciclo_core #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instruction,
    output logic            retire,
    output logic [4:0]      wb_reg,
    output logic [XLEN-1:0] wb_data,
    output logic            halted,
    output logic            illegal
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned RW  = $clog2(NREG);

    localparam logic [6:0] OpReg = 7'b0110011;
    localparam logic [6:0] OpImm = 7'b0010011;
    localparam logic [6:0] OpLui = 7'b0110111;
    localparam logic [6:0] OpSys = 7'b1110011;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExecute,
        StWriteback,
        StHalt
    } state_e;

    state_e          state;
    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] result;

    // Instruction fields
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] fun3;
    logic [6:0] fun7;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign fun3   = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign fun7   = instruction[31:25];

    assign imem_req  = (state == StFetch);
    assign imem_addr = pc;

    // Decode: legality and halt classification
    logic use_rs1;
    logic use_rs2;
    logic use_rd;
    logic is_sys;
    logic fmt_bad;
    logic idx_bad;
    logic shamt_hi_bad;
    logic is_ecall;
    logic is_ebreak;
    logic dec_illegal;
    logic dec_halt;

    // Bit 25 belongs to the shift amount only on 64-bit datapaths.
    assign shamt_hi_bad = (XLEN == 32) ? instruction[25] : 1'b0;
    assign is_ecall     = (instruction[31:7] == 25'd0);
    assign is_ebreak    = (instruction[31:7] == {12'h001, 13'd0});

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        is_sys  = 1'b0;
        fmt_bad = 1'b0;
        case (opcode)
            OpReg: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                fmt_bad = !((fun7 == 7'b0000000) ||
                            ((fun7 == 7'b0100000) && ((fun3 == 3'b000) || (fun3 == 3'b101))));
            end
            OpImm: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                if (fun3 == 3'b001) begin
                    fmt_bad = (instruction[31:26] != 6'b000000) || shamt_hi_bad;
                end else if (fun3 == 3'b101) begin
                    fmt_bad = ((instruction[31:26] != 6'b000000) &&
                               (instruction[31:26] != 6'b010000)) || shamt_hi_bad;
                end
            end
            OpLui: begin
                use_rd = 1'b1;
            end
            OpSys: begin
                is_sys  = 1'b1;
                fmt_bad = !(is_ecall || is_ebreak);
            end
            default: begin
                fmt_bad = 1'b1;
            end
        endcase
    end

    assign idx_bad = (use_rs1 && (32'(rs1) >= NREG)) ||
                     (use_rs2 && (32'(rs2) >= NREG)) ||
                     (use_rd  && (32'(rd)  >= NREG));

    assign dec_illegal = fmt_bad || idx_bad;
    assign dec_halt    = is_sys || dec_illegal;

    // Immediates
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_next;

    assign imm_i    = XLEN'($signed(instruction[31:20]));
    assign imm_u    = XLEN'($signed({instruction[31:12], 12'h000}));
    assign imm_next = (opcode == OpLui) ? imm_u : imm_i;

    // ALU
    logic [XLEN-1:0] src2;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_out;

    assign src2  = (opcode == OpImm) ? imm : op_b;
    assign shamt = src2[SHW-1:0];

    always_comb begin
        alu_out = '0;
        if (opcode == OpLui) begin
            alu_out = imm;
        end else begin
            case (fun3)
                3'b000: alu_out = ((opcode == OpReg) && instruction[30]) ? op_a - src2
                                                                          : op_a + src2;
                3'b001: alu_out = op_a << shamt;
                3'b010: alu_out = XLEN'($signed(op_a) < $signed(src2));
                3'b011: alu_out = XLEN'(op_a < src2);
                3'b100: alu_out = op_a ^ src2;
                3'b101: alu_out = instruction[30] ? XLEN'($signed(op_a) >>> shamt)
                                                  : op_a >> shamt;
                3'b110: alu_out = op_a | src2;
                3'b111: alu_out = op_a & src2;
                default: alu_out = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StFetch;
            pc          <= RESET_PC;
            instruction <= '0;
            op_a        <= '0;
            op_b        <= '0;
            imm         <= '0;
            result      <= '0;
            retire      <= 1'b0;
            wb_reg      <= '0;
            wb_data     <= '0;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                StFetch: begin
                    if (imem_ready) begin
                        instruction <= imem_rdata;
                        state       <= StDecode;
                    end
                end
                StDecode: begin
                    op_a <= regs[rs1[RW-1:0]];
                    op_b <= regs[rs2[RW-1:0]];
                    imm  <= imm_next;
                    if (dec_halt) begin
                        halted  <= 1'b1;
                        illegal <= dec_illegal;
                        state   <= StHalt;
                    end else begin
                        state <= StExecute;
                    end
                end
                StExecute: begin
                    // Retire outputs are registered here so they are valid for the whole WB cycle.
                    result  <= alu_out;
                    retire  <= 1'b1;
                    wb_reg  <= rd;
                    wb_data <= (rd == 5'd0) ? '0 : alu_out;
                    state   <= StWriteback;
                end
                StWriteback: begin
                    if (rd != 5'd0) begin
                        regs[rd[RW-1:0]] <= result;
                    end
                    pc      <= pc + XLEN'(4);
                    retire  <= 1'b0;
                    wb_reg  <= '0;
                    wb_data <= '0;
                    state   <= StFetch;
                end
                StHalt: begin
                    state <= StHalt;
                end
                default: begin
                    state <= StHalt;
                end
            endcase
        end
    end

endmodule

// File: doc/multiciclo_core.md
Name: multiciclo_core

Overview:
- Parametrised multicycle successor of the single-cycle RV32I datapath.
- Executes the integer ALU subset (R-type, I-type ALU, LUI) through a FETCH/DECODE/EXECUTE/WRITEBACK state machine with an internal register file.
- Fetches over a valid/ready instruction-memory handshake, so memories with wait states are supported.
- Supports ECALL/EBREAK halt and illegal-instruction trapping, and exposes retire/debug signals for the bench.

Parameters:
- XLEN, 32, datapath and register width; legal values 32 or 64. Instructions are always 32 bits.
- NREG, 32, architectural register count; 32 (RV32I) or 16 (RV32E).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; held high for the whole FETCH state.
- imem_addr  out  XLEN  fetch address; equals pc.
- imem_ready  in  1  instruction valid; sampled only while imem_req=1.
- imem_rdata  in  32  instruction word; captured on the cycle with imem_req&imem_ready.
- pc  out  XLEN  current PC.
- instruction  out  32  latched instruction register.
- retire  out  1  one-cycle pulse in the WRITEBACK cycle of each completed instruction.
- wb_reg  out  5  rd of the retiring instruction; 0 when not retiring.
- wb_data  out  XLEN  value written to rd; 0 when not retiring.
- halted  out  1  high in HALT state.
- illegal  out  1  sticky flag: halt was caused by an unsupported or illegal encoding.

Behaviour:
- Reset (asynchronous):
  - pc=RESET_PC; instruction=0; all registers 0.
  - state=FETCH; retire=0, wb_reg=0, wb_data=0, halted=0, illegal=0.
  - Assertion mid-instruction aborts it with no register write and no retire.
  - First imem_req is high in the first cycle after reset deasserts.
- FETCH:
  - imem_req=1.
  - imem_ready=1: latch imem_rdata into instruction, go to DECODE.
  - imem_ready=0: stay in FETCH; wait states are unbounded and pc is stable throughout.
- DECODE:
  - Latch A=reg[rs1] and B=reg[rs2].
  - Form immediate: I-type = sign-extended instruction[31:20]; LUI = instruction[31:12]<<12, sign-extended to XLEN.
  - Classify the instruction; go to EXECUTE, or to HALT for ECALL/EBREAK/illegal.
- Supported operations:
  - R-type (opcode 0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. Selected by fun3 and fun7; only fun7 0000000, or 0100000 for SUB/SRA, is legal.
  - I-type (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - LUI (0110111).
  - SYSTEM (1110011) with instruction[31:7]=0 (ECALL) or imm=1 (EBREAK): enter HALT, illegal=0.
- Illegal encodings: any other opcode, an illegal fun7, or a rs1/rs2/rd index >= NREG. Response: enter HALT, illegal=1, no register write.
- EXECUTE: compute result into an internal register.
  - Arithmetic wraps modulo 2^XLEN.
  - Shift amount = low log2(XLEN) bits of B or of the immediate.
  - When XLEN=32, a shamt with instruction[25]=1 is illegal.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned, with the immediate sign-extended before comparison; result is 0 or 1.
- WRITEBACK:
  - reg[rd]=result unless rd=0; x0 always reads 0.
  - retire=1, wb_reg=rd, wb_data = result (0 when rd=0).
  - pc = pc+4, wrapping modulo 2^XLEN; return to FETCH.
- Latency: CPI = 4 + fetch wait cycles. A register written in WRITEBACK is visible to the next instruction's DECODE.
- HALT: terminal. halted=1; imem_req=0; pc remains at the halting instruction; only reset exits.
- imem_ready while imem_req=0: ignored.

Test Plan:
- Reset with imem_ready=1, program `ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2` -> retire every 4 cycles; wb_data = 5, 0xFFFFFFFF_FFFFFFFD truncated to XLEN, then 2; pc advances 0, 4, 8, 12.
- Same program with imem_ready held low 3 cycles per fetch -> imem_addr stable during the waits; 7 cycles per retire; identical results.
- `LUI x4,0x80000; SRAI x5,x4,4; SRLI x6,x4,4; SLTU x7,x0,x4; SLT x8,x4,x0` at XLEN=32 -> 0x80000000, 0xF8000000, 0x08000000, 1, 1.
- `ADDI x0,x0,7` followed by `ADD x9,x0,x0` -> first retire shows wb_reg=0, wb_data=0; x9=0.
- NREG=16 with `ADDI x20,x0,1` -> halted=1, illegal=1, no retire, pc unchanged. Separately, ECALL -> halted=1, illegal=0.
- Reset asserted in the EXECUTE cycle of `ADDI x1,x0,9` -> no retire; x1=0; after release, the fetch restarts at RESET_PC.
